// File: rtl/sram_arbiter_pkg.sv
// ============================================================================
// sram_arbiter_pkg: shared SRAM types, states and timing defaults
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef SRAM_READ_CYCLES
`define SRAM_READ_CYCLES 2
`endif
`ifndef SRAM_WRITE_CYCLES
`define SRAM_WRITE_CYCLES 2
`endif
`ifndef SRAM_STARVE_LIMIT
`define SRAM_STARVE_LIMIT 8
`endif

package sram_arbiter_pkg;

   localparam int SRAM_ADDR_W       = 20;
   localparam int SRAM_DATA_W       = 32;
   localparam int SRAM_READ_CYCLES  = `SRAM_READ_CYCLES;
   localparam int SRAM_WRITE_CYCLES = `SRAM_WRITE_CYCLES;
   localparam int SRAM_STARVE_LIMIT = `SRAM_STARVE_LIMIT;

   typedef logic [SRAM_ADDR_W-1:0] SramAddress_t;
   typedef logic [SRAM_DATA_W-1:0] SramData_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_READ     = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_HOLD  = 3'd4
   } SramArbState_t;

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } SramOwner_t;

endpackage

`default_nettype wire

// File: rtl/sram_phy_sequencer.sv
// ============================================================================
// sram_phy_sequencer: drives registered SRAM strobes for one read or write
// Rev 1.0
// ============================================================================
`default_nettype none

module sram_phy_sequencer
   import sram_arbiter_pkg::*;
#(
   parameter int ADDR_W       = SRAM_ADDR_W,
   parameter int DATA_W       = SRAM_DATA_W,
   parameter int READ_CYCLES  = SRAM_READ_CYCLES,
   parameter int WRITE_CYCLES = SRAM_WRITE_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [3:0]        be_n_i,
   output logic              idle_o,
   output logic              sample_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic [DATA_W-1:0] sram_dq_out_o,
   output logic              sram_dq_oe_o,
   output logic              sram_ce_n_o,
   output logic              sram_oe_n_o,
   output logic              sram_we_n_o,
   output logic [3:0]        sram_be_n_o
);

   localparam int MAX_CYCLES = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_CYCLES - 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_CYCLES - 1);

   SramArbState_t     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        be_n_q;
   logic              ce_n_q, oe_n_q, we_n_q, dq_oe_q;
   logic              accept;

   assign accept = (state_q == ST_IDLE) && start_i;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      sample_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = we_i ? ST_WR_SETUP : ST_READ;
               cnt_d   = '0;
            end
         end
         ST_READ: begin
            if (cnt_q == RD_LAST) begin
               state_d  = ST_IDLE;
               sample_o = 1'b1;
               done_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WR_SETUP: begin
            state_d = ST_WR_PULSE;
            cnt_d   = '0;
         end
         ST_WR_PULSE: begin
            if (cnt_q == WR_LAST) begin
               state_d = ST_WR_HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WR_HOLD: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes are registered from the next state so they line up with it glitch-free.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_n_q  <= 4'hF;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         dq_oe_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         if (accept) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
         end
         if (state_d == ST_IDLE) begin
            be_n_q <= 4'hF;
         end else if (accept) begin
            be_n_q <= be_n_i;
         end
         ce_n_q  <= (state_d == ST_IDLE);
         oe_n_q  <= (state_d != ST_READ);
         we_n_q  <= (state_d != ST_WR_PULSE);
         dq_oe_q <= (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
                    (state_d == ST_WR_HOLD);
      end
   end

   assign idle_o        = (state_q == ST_IDLE);
   assign done_o        = done_q;
   assign sram_addr_o   = addr_q;
   assign sram_dq_out_o = wdata_q;
   assign sram_dq_oe_o  = dq_oe_q;
   assign sram_ce_n_o   = ce_n_q;
   assign sram_oe_n_o   = oe_n_q;
   assign sram_we_n_o   = we_n_q;
   assign sram_be_n_o   = be_n_q;

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
// sram_arbiter: shares one async SRAM between VGA scanout (A) and renderer (B)
// Rev 1.0
// ============================================================================
`default_nettype none

module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ADDR_W       = SRAM_ADDR_W,
   parameter int DATA_W       = SRAM_DATA_W,
   parameter int READ_CYCLES  = SRAM_READ_CYCLES,
   parameter int WRITE_CYCLES = SRAM_WRITE_CYCLES,
   parameter int STARVE_LIMIT = SRAM_STARVE_LIMIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_ack,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   input  logic [3:0]        b_be,
   output logic              b_ack,
   output logic              b_done,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_dq_out,
   output logic              sram_dq_oe,
   input  logic [DATA_W-1:0] sram_dq_in,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [3:0]        sram_be_n
);

   localparam int ST_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [ST_W-1:0] STARVE_MAX = ST_W'(STARVE_LIMIT);

   logic [ST_W-1:0]   starve_q, starve_d;
   SramOwner_t        owner_q;
   logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
   logic              seq_idle, seq_sample, seq_done;
   logic              grant_a, grant_b;

   // Grants are gated by rst so a request held through reset is not acked early.
   always_comb begin
      grant_a  = rst && seq_idle && a_req && !(b_req && (starve_q == STARVE_MAX));
      grant_b  = rst && seq_idle && b_req && !grant_a;
      starve_d = starve_q;
      if (!b_req || grant_b) begin
         starve_d = '0;
      end else if (grant_a && (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q  <= '0;
         owner_q   <= OWN_A;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         starve_q <= starve_d;
         if (grant_a || grant_b) begin
            owner_q <= grant_b ? OWN_B : OWN_A;
         end
         if (seq_sample) begin
            if (owner_q == OWN_A) begin
               a_rdata_q <= sram_dq_in;
            end else begin
               b_rdata_q <= sram_dq_in;
            end
         end
      end
   end

   sram_phy_sequencer #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .READ_CYCLES  (READ_CYCLES),
      .WRITE_CYCLES (WRITE_CYCLES)
   ) u_seq (
      .clk           (clk),
      .rst           (rst),
      .start_i       (grant_a || grant_b),
      .we_i          (grant_b && b_we),
      .addr_i        (grant_b ? b_addr : a_addr),
      .wdata_i       (b_wdata),
      .be_n_i        (grant_b ? ~b_be : 4'h0),
      .idle_o        (seq_idle),
      .sample_o      (seq_sample),
      .done_o        (seq_done),
      .sram_addr_o   (sram_addr),
      .sram_dq_out_o (sram_dq_out),
      .sram_dq_oe_o  (sram_dq_oe),
      .sram_ce_n_o   (sram_ce_n),
      .sram_oe_n_o   (sram_oe_n),
      .sram_we_n_o   (sram_we_n),
      .sram_be_n_o   (sram_be_n)
   );

   // owner_q only changes at the end of an IDLE cycle, so it is still valid while done is high.
   assign a_ack    = grant_a;
   assign b_ack    = grant_b;
   assign a_rvalid = seq_done && (owner_q == OWN_A);
   assign b_done   = seq_done && (owner_q == OWN_B);
   assign a_rdata  = a_rdata_q;
   assign b_rdata  = b_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// tb_sram_arbiter: scoreboard bench for sram_arbiter with a behavioural SRAM
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

   localparam int AW  = 20;
   localparam int DW  = 32;
   localparam int RC  = 2;
   localparam int WC  = 2;
   localparam int LIM = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          a_req = 1'b0;
   logic [AW-1:0] a_addr = '0;
   logic          a_ack, a_rvalid;
   logic [DW-1:0] a_rdata;
   logic          b_req = 1'b0;
   logic          b_we = 1'b0;
   logic [AW-1:0] b_addr = '0;
   logic [DW-1:0] b_wdata = '0;
   logic [3:0]    b_be = 4'h0;
   logic          b_ack, b_done;
   logic [DW-1:0] b_rdata;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_dq_out;
   logic          sram_dq_oe;
   logic [DW-1:0] sram_dq_in = '0;
   logic          sram_ce_n, sram_oe_n, sram_we_n;
   logic [3:0]    sram_be_n;

   sram_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .READ_CYCLES  (RC),
      .WRITE_CYCLES (WC),
      .STARVE_LIMIT (LIM)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .a_req       (a_req),
      .a_addr      (a_addr),
      .a_ack       (a_ack),
      .a_rvalid    (a_rvalid),
      .a_rdata     (a_rdata),
      .b_req       (b_req),
      .b_we        (b_we),
      .b_addr      (b_addr),
      .b_wdata     (b_wdata),
      .b_be        (b_be),
      .b_ack       (b_ack),
      .b_done      (b_done),
      .b_rdata     (b_rdata),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_oe  (sram_dq_oe),
      .sram_dq_in  (sram_dq_in),
      .sram_ce_n   (sram_ce_n),
      .sram_oe_n   (sram_oe_n),
      .sram_we_n   (sram_we_n),
      .sram_be_n   (sram_be_n)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   exp_t          a_q[$];
   exp_t          b_q[$];
   logic          grant_log[$];
   logic [DW-1:0] mem     [logic [AW-1:0]];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];

   int            n_checks = 0;
   int            n_pass = 0;
   int            we_run = 0;
   int            oe_run = 0;
   int            last_a_ack = 0;
   int            last_b_ack = 0;
   logic [DW-1:0] cur_wdata = '0;
   logic [3:0]    cur_be_n = 4'hF;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      return mem.exists(a) ? mem[a] : {12'h5A5, a};
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : {12'h5A5, a};
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                           input logic [3:0] be);
      logic [DW-1:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   // Asynchronous SRAM: read data appears half a cycle after OE, writes land while WE is low.
   always @(negedge clk) begin
      logic [DW-1:0] w;
      if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
         w = mem_rd(sram_addr);
         for (int i = 0; i < 4; i++) if (!sram_be_n[i]) w[8*i +: 8] = sram_dq_out[8*i +: 8];
         mem[sram_addr] = w;
      end
      sram_dq_in <= (!sram_ce_n && !sram_oe_n) ? mem_rd(sram_addr) : '0;
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         we_run = 0;
         oe_run = 0;
      end else begin
         if (a_ack || b_ack) begin
            check("turnaround", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
            grant_log.push_back(b_ack);
         end
         if (a_ack) begin
            e.we = 1'b0; e.addr = a_addr; e.data = ref_rd(a_addr); e.cyc = cyc + RC + 1;
            a_q.push_back(e);
            last_a_ack = cyc;
         end
         if (b_ack) begin
            e.we = b_we; e.addr = b_addr;
            if (b_we) begin
               ref_mem[b_addr] = merge(ref_rd(b_addr), b_wdata, b_be);
               e.data    = ref_mem[b_addr];
               e.cyc     = cyc + WC + 3;
               cur_wdata = b_wdata;
               cur_be_n  = ~b_be;
            end else begin
               e.data = ref_rd(b_addr);
               e.cyc  = cyc + RC + 1;
            end
            b_q.push_back(e);
            last_b_ack = cyc;
         end
         if (a_rvalid) begin
            if (a_q.size() == 0) check("a_rvalid_unexpected", a_rvalid, 1'b0);
            else begin
               e = a_q.pop_front();
               check("a_rdata", a_rdata, e.data);
               check("a_latency", cyc, e.cyc);
            end
         end
         if (b_done) begin
            if (b_q.size() == 0) check("b_done_unexpected", b_done, 1'b0);
            else begin
               e = b_q.pop_front();
               if (e.we) check("b_write_mem", mem_rd(e.addr), e.data);
               else check("b_rdata", b_rdata, e.data);
               check("b_latency", cyc, e.cyc);
            end
         end
         if (!sram_we_n) we_run++;
         else if (we_run != 0) begin
            check("we_n_low_len", we_run, WC);
            we_run = 0;
         end
         if (!sram_oe_n) oe_run++;
         else if (oe_run != 0) begin
            check("oe_n_low_len", oe_run, RC);
            oe_run = 0;
         end
         if (sram_dq_oe) begin
            check("dq_out_stable", sram_dq_out, cur_wdata);
            check("be_n_write", sram_be_n, cur_be_n);
         end
      end
   end

   task automatic drv_a(input logic [AW-1:0] addr);
      logic got;
      got    = 1'b0;
      a_addr = addr;
      a_req  = 1'b1;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         got = a_ack;
      end
      check("a_ack_seen", got, 1'b1);
      @(posedge clk);
      #1;
      a_req = 1'b0;
   endtask

   task automatic drv_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [3:0] be);
      logic got;
      got     = 1'b0;
      b_we    = we;
      b_addr  = addr;
      b_wdata = wdata;
      b_be    = be;
      b_req   = 1'b1;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         got = b_ack;
      end
      check("b_ack_seen", got, 1'b1);
      @(posedge clk);
      #1;
      b_req = 1'b0;
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while ((a_q.size() != 0 || b_q.size() != 0) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("drain", (a_q.size() == 0 && b_q.size() == 0), 1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic seen;
      mem[20'h00010]     = 32'hDEADBEEF;
      ref_mem[20'h00010] = 32'hDEADBEEF;
      mem[20'h12345]     = 32'h11223344;
      ref_mem[20'h12345] = 32'h11223344;

      // Request held through reset must not be acked.
      a_addr = 20'h00010;
      a_req  = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("rst_a_ack", a_ack, 1'b0);
      end
      check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
      check("rst_be_n", sram_be_n, 4'hF);
      check("rst_addr", sram_addr, 20'h0);
      check("rst_pulses", {a_rvalid, b_ack, b_done}, 3'b000);
      check("rst_a_rdata", a_rdata, 32'h0);
      check("rst_b_rdata", b_rdata, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Lone A read
      drv_a(20'h00010);
      @(negedge clk);
      check("rd_c1_oe_n", sram_oe_n, 1'b0);
      check("rd_c1_ce_n", sram_ce_n, 1'b0);
      check("rd_c1_addr", sram_addr, 20'h00010);
      @(negedge clk);
      check("rd_c2_oe_n", sram_oe_n, 1'b0);
      check("rd_c2_rvalid", a_rvalid, 1'b0);
      @(negedge clk);
      check("rd_c3_oe_n", sram_oe_n, 1'b1);
      check("rd_c3_rvalid", a_rvalid, 1'b1);
      check("rd_c3_rdata", a_rdata, 32'hDEADBEEF);
      @(posedge clk);
      #1;

      // Lone B partial write
      drv_b(1'b1, 20'h12345, 32'hCAFEF00D, 4'b0011);
      @(negedge clk);
      check("wr_setup", {sram_ce_n, sram_we_n, sram_dq_oe}, 3'b011);
      check("wr_setup_be_n", sram_be_n, 4'b1100);
      check("wr_setup_addr", sram_addr, 20'h12345);
      @(negedge clk);
      check("wr_pulse1_we_n", sram_we_n, 1'b0);
      @(negedge clk);
      check("wr_pulse2_we_n", sram_we_n, 1'b0);
      @(negedge clk);
      check("wr_hold", {sram_we_n, sram_dq_oe, b_done}, 3'b110);
      @(negedge clk);
      check("wr_done", {b_done, sram_dq_oe}, 2'b10);
      check("wr_mem_word", mem_rd(20'h12345), 32'h1122F00D);
      @(posedge clk);
      #1;

      // B read-back of the merged word
      drv_b(1'b0, 20'h12345, 32'h0, 4'hF);
      wait_drain();
      check("b_readback", b_rdata, 32'h1122F00D);

      // Continuous contention: 8 A grants per forced B grant
      grant_log.delete();
      fork
         begin
            for (int i = 0; i < 17; i++) drv_a(20'h00100 + 20'(i));
         end
         begin
            for (int j = 0; j < 2; j++) drv_b(1'b1, 20'h00200 + 20'(j), 32'hA0000000 + 32'(j), 4'hF);
         end
      join
      wait_drain();
      check("grant_count", grant_log.size(), 19);
      for (int k = 0; k < grant_log.size() && k < 19; k++)
         check("grant_order", grant_log[k], (k == 8 || k == 17));

      // A raised during a B write waits for the next IDLE
      fork
         drv_b(1'b1, 20'h00300, 32'h0BADF00D, 4'hF);
         begin
            repeat (3) @(posedge clk);
            #1;
            drv_a(20'h00300);
         end
      join
      wait_drain();
      check("a_after_write_gap", last_a_ack - last_b_ack, WC + 3);

      // Reset in the middle of the write pulse
      drv_b(1'b1, 20'h00400, 32'h12345678, 4'hF);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = !sram_we_n;
      end
      check("we_pulse_seen", seen, 1'b1);
      #1;
      rst = 1'b0;
      #1;
      check("abort_strobes", {sram_ce_n, sram_we_n, sram_dq_oe}, 3'b110);
      check("abort_be_n", sram_be_n, 4'hF);
      a_q.delete();
      b_q.delete();
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", b_done, 1'b0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      drv_b(1'b1, 20'h00401, 32'h55AA55AA, 4'hF);
      drv_b(1'b0, 20'h00401, 32'h0, 4'hF);
      wait_drain();
      check("post_rst_read", b_rdata, 32'h55AA55AA);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 32-bit asynchronous SRAM between two requesters: the VGA scanout reader (port A, read-only, high priority) and the text/font renderer pixel writer (port B, read/write).
- Sequences the SRAM control strobes for each access and returns read data.
- Guarantees the renderer forward progress through a starvation limit.
- Sits between the renderer sub-blocks, the VGA timing block and the SRAM pins at the top level.

Parameters:
- ADDR_W, 20, SRAM word address width.
- DATA_W, 32, SRAM data width.
- READ_CYCLES, 2, cycles the SRAM address/OE are held before read data is sampled (>=1).
- WRITE_CYCLES, 2, cycles WE_n is held low (>=1).
- STARVE_LIMIT, 8, consecutive port-A grants allowed while port B waits before B is forced (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- a_req  in  1  VGA read request
- a_addr  in  ADDR_W  VGA read address
- a_ack  out  1  1-cycle pulse: request A accepted
- a_rvalid  out  1  1-cycle pulse: a_rdata valid
- a_rdata  out  DATA_W  VGA read data
- b_req  in  1  renderer request
- b_we  in  1  1 = write, 0 = read
- b_addr  in  ADDR_W  renderer address
- b_wdata  in  DATA_W  renderer write data
- b_be  in  4  byte enables, active-high
- b_ack  out  1  1-cycle pulse: request B accepted
- b_done  out  1  1-cycle pulse: B access complete (b_rdata valid if read)
- b_rdata  out  DATA_W  renderer read data
- sram_addr  out  ADDR_W  SRAM address
- sram_dq_out  out  DATA_W  SRAM write data
- sram_dq_oe  out  1  tristate enable for dq
- sram_dq_in  in  DATA_W  SRAM read data
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low
- sram_be_n  out  4  SRAM byte enables, active-low

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-low.
- Reset values:
  - FSM IDLE; starve counter 0; all ack/valid/done outputs 0; a_rdata/b_rdata 0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=4'hF, sram_dq_oe=0, sram_addr=0.
- Reset mid-access: strobes deassert immediately (async); the in-flight access is dropped and no done/rvalid is issued.
- Requests are level-held. A requester keeps req and its fields stable until it sees its ack. Fields are captured on the ack cycle and may change afterwards. One outstanding access per port.
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE arbitration, evaluated every cycle:
  - Grant A if a_req, unless b_req and starve==STARVE_LIMIT.
  - Otherwise grant B if b_req.
  - Ack pulses on the grant cycle; address/data/be/owner are registered.
  - A grant, or B with b_we=0 -> READ. B with b_we=1 -> WR_SETUP.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each A grant while b_req=1.
  - Clears on any B grant or when b_req=0.
- READ:
  - ce_n=0, oe_n=0, dq_oe=0, be_n=0 for A, ~b_be for B.
  - Held READ_CYCLES cycles. In the last cycle sram_dq_in is registered into the owner's rdata.
  - The owner's a_rvalid or b_done pulses the following cycle, together with the return to IDLE.
  - Read latency from ack to rvalid/done = READ_CYCLES+1.
- WR_SETUP: 1 cycle; ce_n=0, we_n=1, dq_oe=1, address/data/be_n driven.
- WR_PULSE: WRITE_CYCLES cycles with we_n=0.
- WR_HOLD: 1 cycle with we_n=1 and dq_oe=1 kept (data hold); b_done pulses the next cycle, back in IDLE.
- Write latency from ack to done = WRITE_CYCLES+3.
- No back-to-back grant: IDLE always occupies at least 1 cycle between accesses. That cycle is the bus turnaround, with all strobes high and dq_oe=0.
- Simultaneous a_req and b_req with starve<STARVE_LIMIT: A wins.
- Outputs are registered: strobes change only on clk edges, never glitch.
- Port A writes do not exist. Addresses are used unchanged, with no wrap or offset arithmetic; frame-buffer offsets are the requesters' job.

Decomposition:
- Shared package/header:
  - SramAddress_t / SramData_t widths
  - SramArbState_t enum
  - `SRAM_READ_CYCLES, `SRAM_WRITE_CYCLES, `SRAM_STARVE_LIMIT defaults, alongside the existing video buffer constants
- One natural sub-module, sram_phy_sequencer:
  - Takes a registered start/we/addr/data/be command and produces strobes, the sampled read data and done.
  - The arbiter top holds arbitration, the starve counter and response routing.

Test Plan:
- Reset → all strobes high, be_n=F, dq_oe=0, no pulses. Hold a_req during reset → no ack until rst rises.
- Lone A read of addr 0x00010, SRAM model returns 0xDEADBEEF → a_ack at cycle 0, oe_n low for 2 cycles, a_rvalid with 0xDEADBEEF at cycle 3.
- Lone B write of addr 0x12345, data 0xCAFEF00D, be=4'b0011 → be_n=4'b1100, we_n low exactly 2 cycles, dq stable setup/hold, b_done at cycle 5; model memory low half updated only.
- a_req and b_req held continuously → exactly 8 A grants, then 1 B grant, repeating. IDLE turnaround cycle with dq_oe=0 between every access.
- b_req alone, then a_req raised mid-write → write completes untouched; A is granted on the next IDLE.
- Assert rst during WR_PULSE → we_n high asynchronously, no b_done; after release, a fresh B request is serviced normally.
